step_sequencer_controller: RTL

Drives the 12-bit note `Select` bus of the polyphonic audio generator from a programmable step pattern. It holds a pattern RAM of `NUM_STEPS` × 12 note bits and runs a Stop/Play/Pause state machine with a cycle-accurate step timer and a gate-length window. It also issues the active-low phase-reset pulse `nStart` to the oscillator bank when playback starts. It sits between the UI/keypad pattern editor and the audio generator.

---
 rtl/step_sequencer_controller_pkg.sv | 11 +
 rtl/step_sequencer_controller_if.sv | 35 +++
 rtl/step_sequencer_controller_step_timer.sv | 56 +++++
 rtl/step_sequencer_controller.sv | 88 ++++++++
 4 files changed

// File: rtl/step_sequencer_controller_pkg.sv
// Shared types and constants for the step sequencer controller.
package seq_pkg;
  localparam int NUM_NOTES  = 12;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2
  } seq_state_t;
endpackage

// File: rtl/step_sequencer_controller_if.sv
// Command, pattern-edit and note-output bundle between the pattern editor,
// the sequencer and the audio generator.
interface step_sequencer_controller_if #(
  parameter int STEP_W = 4,
  parameter int TIME_W = 24
);
  import seq_pkg::*;

  logic                 play;
  logic                 pause;
  logic                 stop;
  logic [TIME_W-1:0]    step_period;
  logic [TIME_W-1:0]    gate_len;
  logic [STEP_W-1:0]    last_step;
  logic                 write_en;
  logic [STEP_W-1:0]    write_step;
  logic [NUM_NOTES-1:0] write_notes;
  logic [NUM_NOTES-1:0] select;
  logic [STEP_W-1:0]    step;
  logic                 step_pulse;
  logic                 playing;
  logic                 n_start;

  modport master (
    output play, pause, stop, step_period, gate_len, last_step,
           write_en, write_step, write_notes,
    input  select, step, step_pulse, playing, n_start
  );

  modport slave (
    input  play, pause, stop, step_period, gate_len, last_step,
           write_en, write_step, write_notes,
    output select, step, step_pulse, playing, n_start
  );
endinterface

// File: rtl/step_sequencer_controller_step_timer.sv
// Per-step tick counter with period/gate latch; flags the last tick of a step
// and whether the gate will be open on the following cycle.
module step_timer
  import seq_pkg::*;
#(
  parameter int TIME_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              clear,
  input  logic [TIME_W-1:0] period_in,
  input  logic [TIME_W-1:0] gate_in,
  output logic              boundary,
  output logic              gate_open_next
);
  localparam logic [TIME_W-1:0] MinPeriod = TIME_W'(MIN_PERIOD);

  logic [TIME_W-1:0] tick, tick_d;
  logic [TIME_W-1:0] period_q, period_d;
  logic [TIME_W-1:0] gate_q, gate_d;
  logic [TIME_W-1:0] period_clamped;

  assign period_clamped = (period_in < MinPeriod) ? MinPeriod : period_in;
  assign boundary       = run && (tick == period_q - TIME_W'(1));

  // A new step (start or boundary) rewinds the tick and re-latches period/gate.
  always_comb begin
    tick_d   = tick;
    period_d = period_q;
    gate_d   = gate_q;
    if (clear) begin
      tick_d = '0;
    end else if (start || boundary) begin
      tick_d   = '0;
      period_d = period_clamped;
      gate_d   = gate_in;
    end else if (run) begin
      tick_d = tick + TIME_W'(1);
    end
    gate_open_next = (tick_d < gate_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick     <= '0;
      period_q <= MinPeriod;
      gate_q   <= '0;
    end else begin
      tick     <= tick_d;
      period_q <= period_d;
      gate_q   <= gate_d;
    end
  end
endmodule

// File: rtl/step_sequencer_controller.sv
// Stop/Play/Pause step sequencer: pattern RAM, step counter and registered
// note-select outputs driving the polyphonic audio generator.
module step_sequencer_controller
  import seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int STEP_W    = 4,
  parameter int TIME_W    = 24
) (
  input logic clk,
  input logic rst,
  step_sequencer_controller_if.slave bus
);
  seq_state_t state, state_d;

  logic [NUM_NOTES-1:0] pattern [NUM_STEPS];
  logic [STEP_W-1:0]    step_q, step_d;
  logic [NUM_NOTES-1:0] select_d;
  logic                 start, run, clear;
  logic                 boundary, gate_open_next;

  // Stop beats Play beats Pause; Play while playing is simply ignored.
  always_comb begin
    state_d = state;
    if (bus.stop) begin
      state_d = STOP;
    end else if (bus.play) begin
      state_d = PLAY;
    end else if (bus.pause && state == PLAY) begin
      state_d = PAUSED;
    end
  end

  assign start = (state == STOP) && (state_d == PLAY);
  assign run   = (state == PLAY) && (state_d == PLAY);
  assign clear = (state_d == STOP);

  step_timer #(.TIME_W(TIME_W)) u_timer (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .run            (run),
    .clear          (clear),
    .period_in      (bus.step_period),
    .gate_in        (bus.gate_len),
    .boundary       (boundary),
    .gate_open_next (gate_open_next)
  );

  always_comb begin
    step_d = step_q;
    if (clear || start) begin
      step_d = '0;
    end else if (boundary) begin
      step_d = (step_q >= bus.last_step) ? '0 : step_q + STEP_W'(1);
    end
    select_d = (state_d == PLAY && gate_open_next) ? pattern[step_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else if (bus.write_en) begin
      pattern[bus.write_step] <= bus.write_notes;
    end
  end

  // Select reads the pre-write RAM, so an edit shows up one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= STOP;
      step_q         <= '0;
      bus.select     <= '0;
      bus.step_pulse <= 1'b0;
      bus.playing    <= 1'b0;
      bus.n_start    <= 1'b1;
    end else begin
      state          <= state_d;
      step_q         <= step_d;
      bus.select     <= select_d;
      bus.step_pulse <= start || boundary;
      bus.playing    <= (state_d == PLAY);
      bus.n_start    <= !start;
    end
  end

  assign bus.step = step_q;
endmodule
